// File: rtl/tone_synth_pkg.sv
// tone_synth_pkg: shared types and helpers for the burst tone generator.
package tone_synth_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned SOURCE_WIDTH_DEFAULT = 14;
  localparam int unsigned PHASE_WIDTH_DEFAULT  = 16;

  // Samples per burst: RUNS windows of 2^FFT_DEPTH samples each.
  function automatic int unsigned burst_len(input int unsigned fft_depth,
                                            input int unsigned runs);
    return runs << fft_depth;
  endfunction

  // Largest positive two's complement value of the given width.
  function automatic int sat_max(input int unsigned width);
    return (1 << (width - 1)) - 1;
  endfunction

  // Most negative two's complement value of the given width.
  function automatic int sat_min(input int unsigned width);
    return -(1 << (width - 1));
  endfunction

  localparam int SAT_MAX_DEFAULT = sat_max(SOURCE_WIDTH_DEFAULT);
  localparam int SAT_MIN_DEFAULT = sat_min(SOURCE_WIDTH_DEFAULT);

endpackage

// File: rtl/tone_synth_if.sv
// tone_synth_if: control and sample bus of the tone generator.
// Optional cont input present when TONE_SYNTH_CONT_EN is defined.
interface tone_synth_if #(
  parameter int PHASE_WIDTH  = 16,
  parameter int SOURCE_WIDTH = 14
);

  logic                           start;
  logic                           abort;
  logic        [PHASE_WIDTH-1:0]  freq_word;
  logic        [PHASE_WIDTH-1:0]  phase_offset;
`ifdef TONE_SYNTH_CONT_EN
  logic                           cont;
`endif
  logic signed [SOURCE_WIDTH-1:0] source;
  logic                           valid;
  logic                           busy;
  logic                           done;

  // Controller / stimulus side.
  modport master (
    output start, abort, freq_word, phase_offset,
`ifdef TONE_SYNTH_CONT_EN
    output cont,
`endif
    input  source, valid, busy, done
  );

  // Generator side.
  modport slave (
    input  start, abort, freq_word, phase_offset,
`ifdef TONE_SYNTH_CONT_EN
    input  cont,
`endif
    output source, valid, busy, done
  );

endinterface

// File: rtl/tone_shaper.sv
// tone_shaper: combinational parabolic sine approximation of the phase.
// Uses the signed top H+1 phase bits p and forms y = 2*p*(2^H - |p|).
module tone_shaper
  import tone_synth_pkg::*;
#(
  parameter int SOURCE_WIDTH = 14,
  parameter int PHASE_WIDTH  = 16
) (
  input  logic        [PHASE_WIDTH-1:0]  phase,
  output logic signed [SOURCE_WIDTH-1:0] sample
);

  localparam int H  = SOURCE_WIDTH / 2;
  localparam int YW = SOURCE_WIDTH + 2;

  localparam logic signed [YW-1:0] YMAX = YW'(sat_max(SOURCE_WIDTH));
  localparam logic signed [YW-1:0] YMIN = YW'(sat_min(SOURCE_WIDTH));

  logic signed [H:0]    p;
  logic        [H:0]    pabs;
  logic        [H:0]    rem;
  logic signed [YW-1:0] pe;
  logic signed [YW-1:0] re;
  logic signed [YW-1:0] y;
  logic signed [YW-1:0] ysat;

  // Low phase bits only add resolution below the shaper's input grain.
  generate
    if (PHASE_WIDTH > H + 1) begin : g_lsbs
      logic unused_lsbs;
      assign unused_lsbs = ^phase[PHASE_WIDTH-H-2:0];
    end
  endgenerate

  // Parabola per half period, then clamp the single overshoot at the peak.
  always_comb begin
    p    = phase[PHASE_WIDTH-1 -: H+1];
    // |-2^H| wraps to 2^H, which is still correct read as unsigned.
    pabs = p[H] ? (H+1)'(-p) : (H+1)'(p);
    rem  = (H+1)'(2 ** H) - pabs;
    pe   = YW'(p);
    re   = $signed(YW'(rem));
    y    = (pe * re) <<< 1;
    ysat = y;
    if (y > YMAX) begin
      ysat = YMAX;
    end else if (y < YMIN) begin
      ysat = YMIN;
    end
    sample = ysat[SOURCE_WIDTH-1:0];
  end

endmodule

// File: rtl/tone_synth.sv
// tone_synth: burst DDS tone generator, one sample every CLK_DIV clocks,
// RUNS*2^FFT_DEPTH samples per burst.
// Optional feature macro: TONE_SYNTH_CONT_EN (adds cont for endless bursts).
module tone_synth
  import tone_synth_pkg::*;
#(
  parameter int SOURCE_WIDTH = 14,
  parameter int PHASE_WIDTH  = 16,
  parameter int FFT_DEPTH    = 11,
  parameter int RUNS         = 3,
  parameter int CLK_DIV      = 5
) (
  input  logic         clk,
  input  logic         reset,
  tone_synth_if.slave  bus
);

  localparam int unsigned N     = burst_len(FFT_DEPTH, RUNS);
  localparam int          CNT_W = $clog2(N + 1);
  localparam int          DIV_W = $clog2(CLK_DIV + 1);

  state_t                         state;
  logic        [PHASE_WIDTH-1:0]  acc;
  logic        [PHASE_WIDTH-1:0]  freq;
  logic        [DIV_W-1:0]        div;
  logic        [CNT_W-1:0]        count;
  logic signed [SOURCE_WIDTH-1:0] source_q;
  logic signed [SOURCE_WIDTH-1:0] shaped;
  logic                           valid_q;
  logic                           busy_q;
  logic                           done_q;
  logic                           tick;
  logic                           last;
  logic                           keep_running;

  tone_shaper #(
    .SOURCE_WIDTH (SOURCE_WIDTH),
    .PHASE_WIDTH  (PHASE_WIDTH)
  ) u_shaper (
    .phase  (acc),
    .sample (shaped)
  );

  assign tick = (div == DIV_W'(CLK_DIV - 1));
  assign last = (count == CNT_W'(N - 1));

`ifdef TONE_SYNTH_CONT_EN
  assign keep_running = bus.cont;
`else
  assign keep_running = 1'b0;
`endif

  // Burst FSM, sample divider, phase accumulator and registered outputs.
  always_ff @(posedge clk) begin
    valid_q <= 1'b0;
    done_q  <= 1'b0;
    if (reset) begin
      state    <= IDLE;
      acc      <= '0;
      freq     <= '0;
      div      <= '0;
      count    <= '0;
      source_q <= '0;
      busy_q   <= 1'b0;
    end else if (bus.abort) begin
      state    <= IDLE;
      div      <= '0;
      count    <= '0;
      source_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            freq   <= bus.freq_word;
            acc    <= bus.phase_offset;
            div    <= '0;
            count  <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          if (tick) begin
            div      <= '0;
            source_q <= shaped;
            valid_q  <= 1'b1;
            acc      <= acc + freq;
            if (last) begin
              count <= '0;
              if (!keep_running) begin
                state  <= IDLE;
                busy_q <= 1'b0;
                done_q <= 1'b1;
              end
            end else begin
              count <= count + 1'b1;
            end
          end else begin
            div <= div + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.source = source_q;
  assign bus.valid  = valid_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_tone_synth.sv
// tb_tone_synth: randomized bench for tone_synth against a cycle-level
// behavioural model (phase = offset + k*freq, parabola by integer math).
module tb_tone_synth;

  localparam int SW  = 14;
  localparam int PW  = 16;
  localparam int FD  = 11;
  localparam int RN  = 3;
  localparam int DIV = 5;
  localparam int NS  = RN * (1 << FD);
`ifdef TONE_SYNTH_CONT_EN
  localparam bit HAS_CONT = 1'b1;
`else
  localparam bit HAS_CONT = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;

  tone_synth_if #(.PHASE_WIDTH(PW), .SOURCE_WIDTH(SW)) bus ();

  tone_synth #(
    .SOURCE_WIDTH (SW),
    .PHASE_WIDTH  (PW),
    .FFT_DEPTH    (FD),
    .RUNS         (RN),
    .CLK_DIV      (DIV)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  bit            m_run = 1'b0;
  int            m_cyc = 0;
  int unsigned   m_k   = 0;
  logic [PW-1:0] m_po  = '0;
  logic [PW-1:0] m_fw  = '0;
  int            m_src = 0;
  int            dut_valids = 0;
  int            dut_dones  = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_shape(input int unsigned ph);
    int half;
    int t;
    int y;
    half = SW / 2;
    t = int'((ph >> (PW - half - 1)) % (1 << (half + 1)));
    if (t >= (1 << half)) t -= (1 << (half + 1));
    y = 2 * t * ((1 << half) - ((t < 0) ? -t : t));
    if (y > (1 << (SW - 1)) - 1) y = (1 << (SW - 1)) - 1;
    return y;
  endfunction

  // One clock: drive inputs, let the edge happen, update model, check.
  task automatic cycle(input bit rst, input bit st, input bit ab, input bit ct,
                       input logic [PW-1:0] po, input logic [PW-1:0] fw);
    bit ev;
    bit ed;
    bit ct_eff;
    int unsigned ph;
    reset            = rst;
    bus.start        = st;
    bus.abort        = ab;
    bus.freq_word    = fw;
    bus.phase_offset = po;
`ifdef TONE_SYNTH_CONT_EN
    bus.cont         = ct;
`endif
    ct_eff = ct & HAS_CONT;
    @(posedge clk);
    ev = 1'b0;
    ed = 1'b0;
    if (rst || ab) begin
      m_run = 1'b0;
      m_src = 0;
    end else if (!m_run) begin
      if (st) begin
        m_run = 1'b1;
        m_cyc = 0;
        m_k   = 0;
        m_po  = po;
        m_fw  = fw;
      end
    end else begin
      m_cyc++;
      if (m_cyc % DIV == 0) begin
        ev = 1'b1;
        ph = (int'(m_po) + m_k * int'(m_fw)) & ((1 << PW) - 1);
        m_src = ref_shape(ph);
        m_k++;
        if ((m_k % NS) == 0 && !ct_eff) begin
          ed    = 1'b1;
          m_run = 1'b0;
        end
      end
    end
    @(negedge clk);
    if (bus.valid === 1'b1) dut_valids++;
    if (bus.done === 1'b1) dut_dones++;
    check("valid", int'(bus.valid), int'(ev));
    check("done", int'(bus.done), int'(ed));
    check("busy", int'(bus.busy), int'(m_run));
    check("source", int'(bus.source), m_src);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, PW'($urandom), PW'($urandom));
  endtask

  // Run until the model has produced 'target' samples or the burst ends.
  task automatic run_samples(input int unsigned target, input int unsigned cont_until);
    int guard;
    guard = 0;
    while (m_run && m_k < target) begin
      cycle(1'b0, 1'b0, 1'b0, (m_k < cont_until), PW'($urandom), PW'($urandom));
      guard++;
      if (guard > 80000) begin
        check("timeout", int'(m_k), int'(target));
        break;
      end
    end
  endtask

  task automatic start_burst(input logic [PW-1:0] po, input logic [PW-1:0] fw);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, po, fw);
  endtask

  task automatic do_abort();
    cycle(1'b0, 1'b0, 1'b1, 1'b0, PW'($urandom), PW'($urandom));
  endtask

  initial begin
    int v0;
    int d0;
    logic [PW-1:0] po;
    logic [PW-1:0] fw;
    reset            = 1'b1;
    bus.start        = 1'b0;
    bus.abort        = 1'b0;
    bus.freq_word    = '0;
    bus.phase_offset = '0;
`ifdef TONE_SYNTH_CONT_EN
    bus.cont         = 1'b0;
`endif
    @(negedge clk);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
    idle(3);

    // full burst, quarter-period steps; cont build holds cont past one wrap
    dut_valids = 0;
    dut_dones  = 0;
    start_burst(16'd0, 16'd16384);
    run_samples(3 * NS, HAS_CONT ? NS + 56 : 0);
    check("burst_valids", dut_valids, HAS_CONT ? 2 * NS : NS);
    check("burst_dones", dut_dones, 1);
    idle(5);
    check("hold_source", int'(bus.source), -8192);
    check("busy_after", int'(bus.busy), 0);

    // constant phase at the positive and negative peaks
    start_burst(16'd16384, 16'd0);
    run_samples(30, 0);
    check("peak_pos", int'(bus.source), 8191);
    do_abort();
    start_burst(16'd49152, 16'd0);
    run_samples(30, 0);
    check("peak_neg", int'(bus.source), -8192);
    do_abort();
    idle(2);

    // abort after sample 100, restart on the very next cycle
    d0 = dut_dones;
    start_burst(PW'($urandom), PW'($urandom));
    run_samples(100, 0);
    do_abort();
    check("abort_busy", int'(bus.busy), 0);
    check("abort_source", int'(bus.source), 0);
    start_burst(PW'($urandom), PW'($urandom));
    check("restart_busy", int'(bus.busy), 1);
    run_samples(20, 0);
    do_abort();
    check("abort_no_done", dut_dones, d0);

    // start re-issued mid-burst is ignored; reset mid-burst clears outputs
    start_burst(PW'($urandom), PW'($urandom));
    run_samples(40, 0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, PW'($urandom), PW'($urandom));
    run_samples(80, 0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, PW'($urandom), PW'($urandom));
    check("reset_source", int'(bus.source), 0);
    idle(2);

    // random bursts, aborted on a tick edge; abort beats start in idle
    for (int i = 0; i < 6; i++) begin
      po = PW'($urandom);
      fw = PW'($urandom);
      start_burst(po, fw);
      run_samples($urandom_range(5, 60), 0);
      while (m_run && ((m_cyc + 1) % DIV) != 0) idle(1);
      v0 = dut_valids;
      cycle(1'b0, 1'b1, 1'b1, 1'b0, PW'($urandom), PW'($urandom));
      check("abort_vs_tick", dut_valids, v0);
      cycle(1'b0, 1'b1, 1'b1, 1'b0, PW'($urandom), PW'($urandom));
      idle(3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
